// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file types for the write-back path: address/data widths and the write request record.
package regfile_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid at or after ptr, wrapping; zero latency, no state.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);
  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_any && valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back port sharing with a RAW pending scoreboard; 1-cycle registered write, always drains.
// REGFILE_WB_FWD_EN adds a write-through bypass of the in-flight write onto the rs1/rs2 query ports.
module regfile_wb_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic                          issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]         issue_rd_i,
  input  logic [ADDR_WIDTH-1:0]         rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0]         rs2_addr_i,
  output logic                          rs1_busy_o,
  output logic                          rs2_busy_o,
  output logic                          fwd_rs1_valid_o,
  output logic                          fwd_rs2_valid_o,
  output logic [DATA_WIDTH-1:0]         fwd_rs1_data_o,
  output logic [DATA_WIDTH-1:0]         fwd_rs2_data_o,
  output logic                          rf_we_o,
  output logic [ADDR_WIDTH-1:0]         rf_waddr_o,
  output logic [DATA_WIDTH-1:0]         rf_wdata_o,
  output logic [NUM_REGS-1:0]           pending_o
);
  import regfile_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  wb_req_t            win;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_nxt;

  rr_arbiter #(.N(NUM_REQ), .IW(PW)) u_arb (
    .valid     (req_valid_i),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready_o = grant;
  assign pending_o   = pending_q;

  always_comb begin
    win.addr = req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win.data = req_data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Set is applied after clear so a re-issue of the register being written stays pending.
  always_comb begin
    pending_nxt = pending_q;
    if (rf_we_o) pending_nxt[rf_waddr_o] = 1'b0;
    if (issue_valid_i && issue_rd_i != '0) pending_nxt[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      ptr        <= '0;
      pending_q  <= '0;
    end else begin
      pending_q <= pending_nxt;
      rf_we_o   <= grant_any && (win.addr != '0);
      if (grant_any) begin
        rf_waddr_o <= win.addr;
        rf_wdata_o <= win.data;
        if (int'(grant_idx) == NUM_REQ - 1) ptr <= '0;
        else                                ptr <= grant_idx + 1'b1;
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_rs1_valid_o = rf_we_o && (rf_waddr_o == rs1_addr_i) && (rs1_addr_i != '0);
  assign fwd_rs2_valid_o = rf_we_o && (rf_waddr_o == rs2_addr_i) && (rs2_addr_i != '0);
  assign fwd_rs1_data_o  = rf_wdata_o;
  assign fwd_rs2_data_o  = rf_wdata_o;
  assign rs1_busy_o = pending_q[rs1_addr_i] && (rs1_addr_i != '0) && !fwd_rs1_valid_o;
  assign rs2_busy_o = pending_q[rs2_addr_i] && (rs2_addr_i != '0) && !fwd_rs2_valid_o;
`else
  assign fwd_rs1_valid_o = 1'b0;
  assign fwd_rs2_valid_o = 1'b0;
  assign fwd_rs1_data_o  = '0;
  assign fwd_rs2_data_o  = '0;
  assign rs1_busy_o = pending_q[rs1_addr_i] && (rs1_addr_i != '0);
  assign rs2_busy_o = pending_q[rs2_addr_i] && (rs2_addr_i != '0);
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic against a queue-based reference model.
module tb_regfile_wb_scheduler;
  localparam int NR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic        busy1, busy2, fv1, fv2;
  logic [31:0] fd1, fd2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .rs1_busy_o(busy1), .rs2_busy_o(busy2),
    .fwd_rs1_valid_o(fv1), .fwd_rs2_valid_o(fv2),
    .fwd_rs1_data_o(fd1), .fwd_rs2_data_o(fd2),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .pending_o(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_n = 0;

  // Reference model state: rotation start, outstanding registers, write in flight (addr 0 = none).
  int          m_ptr = 0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic check_query(input string nm, input logic [4:0] rs, input logic busy,
                             input logic fv, input logic [31:0] fd);
    logic hit;
    hit = (m_wr_addr != 0) && (m_wr_addr == rs);
`ifdef REGFILE_WB_FWD_EN
    check({nm, "_fwd_vld"}, fv, hit);
    if (hit) check({nm, "_fwd_dat"}, fd, m_wr_data);
    check({nm, "_busy"}, busy, m_pend[rs] && rs != 0 && !hit);
`else
    check({nm, "_fwd_vld"}, fv, 0);
    check({nm, "_fwd_dat"}, fd, 0);
    check({nm, "_busy"}, busy, m_pend[rs] && rs != 0);
`endif
  endtask

  // Called mid-cycle: compare against the model, then advance the model across the next edge.
  task automatic step();
    int g;
    logic [1:0]  exp_rdy;
    logic [4:0]  a;
    logic [31:0] d;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (g < 0 && req_valid[j]) g = j;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready", req_ready, exp_rdy);
    check("pending", pending, m_pend);
    check_query("rs1", rs1, busy1, fv1, fd1);
    check_query("rs2", rs2, busy2, fv2, fd2);

    if (m_wr_addr != 0) m_pend[m_wr_addr] = 1'b0;
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    m_wr_addr = '0;
    if (g >= 0) begin
      a = req_addr[g*5 +: 5];
      d = req_data[g*32 +: 32];
      m_ptr = (g + 1) % NR;
      if (a != 0) begin
        q.push_back('{addr: a, data: d, due: cyc_n + 1});
        m_wr_addr = a;
        m_wr_data = d;
      end
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1, input logic iv,
                     input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input bit do_rst);
    req_valid   = v;
    req_addr    = {a1, a0};
    req_data    = {d1, d0};
    issue_valid = iv;
    issue_rd    = rd;
    rs1         = r1;
    rs2         = r2;
    if (do_rst) begin
      #1;
      check("pre_rst_we", rf_we, 1);
      check("pre_rst_pend", pending, 32'h80);
      rst = 1'b1;
      #1;
      check("rst_we", rf_we, 0);
      check("rst_pend", pending, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_busy1", busy1, 0);
      q.delete();
      m_pend = '0; m_wr_addr = '0; m_ptr = 0;
      rst = 1'b0;
      #1;
      check("post_rst_rdy", req_ready, 2'b01);
    end
    @(negedge clk);
    step();
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic idle(input logic [4:0] r1);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, r1, 5'd0, 1'b0);
  endtask

  // Monitor: every registered write must match the oldest accepted request, exactly one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rf_we) begin
          if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_write (cycle %0d): got addr 0x%0h, expected no write", cyc_n, rf_waddr);
          end else begin
            e = q.pop_front();
            check("wr_cycle", rf_we ? cyc_n : -1, e.due);
            check("wr_addr", rf_waddr, e.addr);
            check("wr_data", rf_wdata, e.data);
          end
        end else if (q.size() > 0 && q[0].due <= cyc_n) begin
          n_cmp++; n_err++;
          $display("FAIL missing_write (cycle %0d): got rf_we 0, expected write to 0x%0h", cyc_n, q[0].addr);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2;
    check("init_we", rf_we, 0);
    check("init_waddr", rf_waddr, 0);
    check("init_wdata", rf_wdata, 0);
    check("init_pend", pending, 0);
    #10 rst = 1'b0;
    @(posedge clk); cyc_n++; #1;

    // single write from req0
    cyc(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(5'd0);
    // contention: both valid every cycle
    for (int i = 0; i < 4; i++)
      cyc(2'b11, 5'd3, $urandom, 5'd4, $urandom, 1'b0, 5'd0, 5'd3, 5'd4, 1'b0);
    idle(5'd0);
    // x0 discard
    cyc(2'b10, 5'd0, 32'd0, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(5'd0);
    // scoreboard lifetime of rd=7
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    idle(5'd7);
    cyc(2'b01, 5'd7, 32'hCAFE0007, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7, 1'b0);
    idle(5'd7);
    idle(5'd7);
    check("sb7_cleared", pending[7], 0);
    // set/clear collision on 9
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    cyc(2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    check("collide_p9", pending[9], 1);
    cyc(2'b01, 5'd9, 32'h999, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
    idle(5'd9);
    // async reset during a registered write with pending=0x80
    cyc(2'b01, 5'd5, 32'h55, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd5, 1'b0);
    cyc(2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 1'b1);
    idle(5'd1);

    for (int i = 0; i < 600; i++) begin
      logic [4:0] a0, a1;
      a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      cyc(2'($urandom_range(0, 3)), a0, $urandom, a1, $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b0);
    end
    idle(5'd0);
    idle(5'd0);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
